// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit: FSM state encoding,
// opcode constants, instruction field positions and the control bundle.
package proc_pkg;

  // Control steps of one instruction; T0 doubles as fetch and idle.
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Opcode values held in the III field. 100-111 execute as no-ops.
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Instruction field positions: III = [8:6], XXX = [5:3], YYY = [2:0].
  localparam int III_LSB = 6;
  localparam int XXX_LSB = 3;
  localparam int YYY_LSB = 0;

  // Every datapath control produced in one cycle, grouped so the decoder
  // can clear them all with a single default assignment.
  typedef struct packed {
    logic [2:0] rin_sel;
    logic       rin_en;
    logic [2:0] rout_sel;
    logic       rout_en;
    logic       irin;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       addsub;
    logic       done;
  } ctrl_t;

endpackage : proc_pkg

// File: rtl/regn.sv
// Generic W-bit register with load enable and synchronous active-high reset.
module regn #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next value: hold unless the load enable is asserted.
  always_comb begin
    // NOTE: assign a default before any conditional so no path leaves q_d
    // unassigned; a missing default in always_comb infers a latch.
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Storage with synchronous reset taking priority over the load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : regn

// File: rtl/proc_ctrl.sv
// Control unit of a simple multi-cycle processor: fetches an instruction
// into IR when Run is seen in T0, then sequences mv / mvi / add / sub /
// no-op through T1..T3, decoding datapath controls from state and IR.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Run,
  input  logic [IW-1:0] DIN,
  output logic [2:0]    RinSel,
  output logic          RinEn,
  output logic [2:0]    RoutSel,
  output logic          RoutEn,
  output logic          IRin,
  output logic          DINout,
  output logic          Ain,
  output logic          Gin,
  output logic          Gout,
  output logic          AddSub,
  output logic          Done,
  output logic [IW-1:0] IR
);

  state_t        state_d;
  state_t        state_q;
  ctrl_t         ctrl;
  logic          ir_load;
  logic [IW-1:0] ir_q;
  logic [2:0]    iii;
  logic [2:0]    xxx;
  logic [2:0]    yyy;

  // IR loads only at an edge where the FSM is in T0 and Run is high.
  assign ir_load = (state_q == T0) && Run;

  regn #(
    .W (IW)
  ) u_ir (
    .clk (Clock),
    .rst (Reset),
    .en  (ir_load),
    .d   (DIN),
    .q   (ir_q)
  );

  assign iii = ir_q[III_LSB +: 3];
  assign xxx = ir_q[XXX_LSB +: 3];
  assign yyy = ir_q[YYY_LSB +: 3];

  // State register; reset returns to T0 and abandons any instruction.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode. All controls default to 0, which also
  // forces the register selects to 0 whenever their enable is low.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      T0: begin
        ctrl.irin = Run;
        if (Run) begin
          state_d = T1;
        end
      end
      T1: begin
        unique case (iii)
          OP_MV: begin
            ctrl.rout_en  = 1'b1;
            ctrl.rout_sel = yyy;
            ctrl.rin_en   = 1'b1;
            ctrl.rin_sel  = xxx;
            ctrl.done     = 1'b1;
            state_d       = T0;
          end
          OP_MVI: begin
            ctrl.dinout  = 1'b1;
            ctrl.rin_en  = 1'b1;
            ctrl.rin_sel = xxx;
            ctrl.done    = 1'b1;
            state_d      = T0;
          end
          OP_ADD, OP_SUB: begin
            ctrl.rout_en  = 1'b1;
            ctrl.rout_sel = xxx;
            ctrl.ain      = 1'b1;
            state_d       = T2;
          end
          default: begin
            ctrl.done = 1'b1;
            state_d   = T0;
          end
        endcase
      end
      T2: begin
        // Only add/sub reach T2; III[0] distinguishes sub from add.
        ctrl.rout_en  = 1'b1;
        ctrl.rout_sel = yyy;
        ctrl.gin      = 1'b1;
        ctrl.addsub   = iii[0];
        state_d       = T3;
      end
      T3: begin
        ctrl.gout    = 1'b1;
        ctrl.rin_en  = 1'b1;
        ctrl.rin_sel = xxx;
        ctrl.done    = 1'b1;
        state_d      = T0;
      end
      default: begin
        state_d = T0;
      end
    endcase
  end

  assign RinSel  = ctrl.rin_sel;
  assign RinEn   = ctrl.rin_en;
  assign RoutSel = ctrl.rout_sel;
  assign RoutEn  = ctrl.rout_en;
  assign IRin    = ctrl.irin;
  assign DINout  = ctrl.dinout;
  assign Ain     = ctrl.ain;
  assign Gin     = ctrl.gin;
  assign Gout    = ctrl.gout;
  assign AddSub  = ctrl.addsub;
  assign Done    = ctrl.done;
  assign IR      = ir_q;

endmodule : proc_ctrl
